// File: rtl/pipe_elastic_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_elastic_stage_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 clr_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     main_q, main_d;
    logic [WIDTH-1:0]     skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_fire;
    logic                 out_fire;

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = main_q;
    assign stall_count = cnt_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and storage update; flush forces an empty bubble.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Stall counter: clear beats increment, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (out_valid_q && !out_ready && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, payload and handshake flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_stage_reg.sv
// Testbench for pipe_elastic_stage_reg: directed vector table,
// async reset check and randomized run against a queue model.
module tb_pipe_elastic_stage_reg;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       clr_count;
    logic [1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_elastic_stage_reg #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .CNT_WIDTH   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clr_count   (clr_count),
        .stall_count (stall_count)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] id,
                                logic ordy, logic clr, logic e_ir,
                                logic e_ov, logic [7:0] e_od,
                                logic [1:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ir,
                           input logic e_ov, input logic [7:0] e_od,
                           input logic [1:0] e_cnt);
        chk({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, e_ir});
        chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, e_ov});
        chk({tag, ".out_data"}, {8'd0, out_data}, {8'd0, e_od});
        chk({tag, ".stall_count"}, {14'd0, stall_count}, {14'd0, e_cnt});
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] id,
                         input logic ordy, input logic clr);
        @(negedge clk);
        flush = fl; in_valid = iv; in_data = id;
        out_ready = ordy; clr_count = clr;
    endtask

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_last;
    int         m_cnt;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        out_ready = 1'b1; clr_count = 1'b0;

        // Directed table
        tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 1, 1, 8'hA5, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 8'(k), 1, 0, 1, 1, 8'(k), 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h08, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 1, 1, 8'h11, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 1, 8'h11, 2));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 1, 8'h11, 3));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 1, 8'h11, 3));
        tbl.push_back(mk(0, 1, 8'h33, 1, 0, 1, 1, 8'h22, 3));
        tbl.push_back(mk(0, 1, 8'h33, 1, 0, 1, 1, 8'h33, 3));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h33, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 8'h33, 0));
        tbl.push_back(mk(0, 1, 8'h61, 0, 0, 1, 1, 8'h61, 0));
        tbl.push_back(mk(0, 1, 8'h62, 0, 0, 0, 1, 8'h61, 1));
        tbl.push_back(mk(1, 1, 8'h44, 0, 0, 1, 0, RV, 2));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, RV, 2));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, RV, 0));
        tbl.push_back(mk(0, 1, 8'h71, 0, 0, 1, 1, 8'h71, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h71, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h71, 2));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h71, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h71, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h71, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h71, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h71, 0));

        // Reset held with upstream pushing
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b1, 1'b0, RV, 2'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            if (i > 0) drive(v.fl, v.iv, v.id, v.ordy, v.clr);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), v.e_ir, v.e_ov, v.e_od,
                    v.e_cnt);
        end

        // Async reset while FULL, between edges
        drive(0, 1, 8'h81, 0, 0);
        drive(0, 1, 8'h82, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_arst.in_ready", {15'd0, in_ready}, 16'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("arst", 1'b1, 1'b0, RV, 2'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against a queue model
        mq.delete();
        m_last = RV;
        m_cnt  = 0;
        for (int c = 0; c < 600; c++) begin
            logic fl, iv, ordy, clr;
            logic [7:0] id;
            logic infire, outfire;
            logic [7:0] e_od;
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            id   = 8'($urandom);
            drive(fl, iv, id, ordy, clr);

            infire  = iv && (mq.size() < 2);
            outfire = (mq.size() > 0) && ordy;
            if (clr)
                m_cnt = 0;
            else if (mq.size() > 0 && !ordy && m_cnt < 3)
                m_cnt++;
            if (fl) begin
                mq.delete();
                m_last = RV;
            end else begin
                if (outfire) m_last = mq.pop_front();
                if (infire) mq.push_back(id);
            end
            e_od = (mq.size() > 0) ? mq[0] : m_last;

            @(posedge clk);
            #1;
            chk_all("rand", mq.size() < 2, mq.size() > 0, e_od,
                    2'(m_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_stage_reg.md
Name: pipe_elastic_stage_reg

Overview:
- Parametrised successor to the fixed-width, always-loading stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM).
- Carries one packed payload bus per stage boundary with a valid/ready handshake, a 2-entry skid buffer (registered in_ready, full throughput), synchronous flush to bubble, and a saturating back-pressure counter.
- Instantiated once per stage boundary; the control and data fields of a stage are concatenated into in_data.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VALUE, 0, value of out_data and skid storage after reset and after flush (WIDTH bits)
CNT_WIDTH, 16, width of stall_count (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (rst=0 resets)
flush  input  1  synchronous flush; drops all held entries this edge
in_valid  input  1  upstream has data on in_data
in_ready  output  1  stage can accept; registered
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry; registered
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload to next stage; registered
clr_count  input  1  synchronous clear of stall_count
stall_count  output  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data/out_valid) and skid register.
- States: EMPTY (no entries), BUSY (main only), FULL (main+skid).
- Registered outputs: in_ready=1 in EMPTY/BUSY, 0 in FULL. out_valid=1 in BUSY/FULL.
- Reset (rst=0, asynchronous, any cycle including mid-transfer):
  - state EMPTY, out_valid=0, in_ready=1.
  - out_data and skid = RESET_VALUE; stall_count=0.
- Transitions (flush=0):
  - EMPTY: in_fire -> BUSY, main<=in_data. Otherwise stay.
  - BUSY, in_fire & out_fire -> BUSY, main<=in_data.
  - BUSY, in_fire & !out_fire -> FULL, skid<=in_data, main held.
  - BUSY, !in_fire & out_fire -> EMPTY, main data held, out_valid=0.
  - BUSY, neither -> hold.
  - FULL: in_ready=0, no accept. out_fire -> BUSY, main<=skid. Otherwise hold.
- Flush=1 overrides every handshake:
  - next state EMPTY, out_valid=0, in_ready=1.
  - main and skid <= RESET_VALUE.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by downstream.
- Ordering: strict FIFO; no entry duplicated or lost except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Latency and throughput: 1 cycle in_fire to out_valid. With out_ready held at 1, one transfer per cycle, no bubbles. in_ready has no combinational path from out_ready.
- Counter: +1 each cycle with out_valid=1 & out_ready=0. Saturates at 2^CNT_WIDTH-1.
  - clr_count=1 -> 0 next edge; clear wins over a same-cycle increment.
  - Flush does not affect the counter.
- WIDTH=1 and CNT_WIDTH=1 are legal; no X on any output after reset.

Test Plan:
- Reset: hold rst=0 with in_valid=1, in_data=0xA5 -> out_valid=0, in_ready=1, out_data=RESET_VALUE, stall_count=0. Release: first edge loads 0xA5, out_valid=1 next cycle.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle later. in_ready stays 1; stall_count stays 0.
- Back-pressure: out_ready=0, push 0x11,0x22,0x33 -> 0x11 and 0x22 accepted, in_ready=0 after the second. out_data stays 0x11; stall_count increments each cycle. Raise out_ready -> 0x11,0x22,0x33 delivered in order.
- Flush in FULL with in_valid=1, in_data=0x44 -> next cycle out_valid=0, out_data=RESET_VALUE, in_ready=1. 0x44 never appears on the output.
- Saturation and clear, CNT_WIDTH=2: 5 stall cycles -> stall_count 1,2,3,3,3. clr_count asserted during a stall cycle -> 0 next cycle.
- Async reset mid-stream (rst low between edges while FULL) -> outputs return to reset values immediately, without waiting for a clock edge.
